// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the USB transmit packet sequencer and its bit counter.
package tx_seq_pkg;

    localparam int          MAX_LEN_DEFAULT   = 64;
    localparam int          LEN_W_DEFAULT     = 7;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h80;
    localparam int          BYTE_BITS         = 8;
    localparam int          BIT_CNT_W         = $clog2(BYTE_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EOP
    } seq_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Wrapping bit-position counter; wrap is high on the last bit of each byte.
module tx_bit_counter
    import tx_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    logic [BIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + BIT_CNT_W'(1);
        end
    end

    assign wrap = (count == '1);

endmodule

// File: rtl/tx_packet_sequencer.sv
// Feeds the TX shifter one byte every 8 cycles: SYNC first, then FIFO payload, then a one-cycle eop.
module tx_packet_sequencer
    import tx_seq_pkg::*;
#(
    parameter int         MAX_LEN   = MAX_LEN_DEFAULT,
    parameter int         LEN_W     = LEN_W_DEFAULT,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic             load_enable,
    output logic [7:0]       data,
    output logic             eop,
    output logic             busy,
    output logic             tx_done,
    output logic             underrun
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [LEN_W-1:0] rem_cnt;
    logic [LEN_W-1:0] rem_next;
    logic             start_ok;
    logic             load_due;
    logic             bit_wrap;

    logic             fifo_rd_d;
    logic             load_d;
    logic [7:0]       data_d;
    logic             eop_d;
    logic             busy_d;
    logic             done_d;
    logic             underrun_d;

    assign start_ok = tx_start && (tx_len <= LEN_W'(MAX_LEN));
    assign load_due = (state == SHIFT) && bit_wrap;

    tx_bit_counter u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != SHIFT),
        .enable (state == SHIFT),
        .wrap   (bit_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A missing byte or an exhausted count both end the packet at the next byte slot.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_ok) state_next = SHIFT;
            SHIFT: if (load_due && ((rem_cnt == '0) || fifo_empty)) state_next = EOP;
            EOP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_d  = 1'b0;
        load_d     = 1'b0;
        data_d     = 8'h00;
        eop_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        rem_next   = rem_cnt;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    load_d   = 1'b1;
                    data_d   = SYNC_BYTE;
                    busy_d   = 1'b1;
                    rem_next = tx_len;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (load_due) begin
                    if (rem_cnt == '0) begin
                        eop_d = 1'b1;
                    end else if (fifo_empty) begin
                        eop_d      = 1'b1;
                        underrun_d = 1'b1;
                    end else begin
                        load_d    = 1'b1;
                        data_d    = fifo_rdata;
                        fifo_rd_d = 1'b1;
                        rem_next  = rem_cnt - LEN_W'(1);
                    end
                end
            end
            EOP: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are computed one cycle early so the shifter sees clean registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_cnt     <= '0;
            fifo_rd     <= 1'b0;
            load_enable <= 1'b0;
            data        <= 8'h00;
            eop         <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rem_cnt     <= rem_next;
            fifo_rd     <= fifo_rd_d;
            load_enable <= load_d;
            data        <= data_d;
            eop         <= eop_d;
            busy        <= busy_d;
            tx_done     <= done_d;
            underrun    <= underrun_d;
        end
    end

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Directed bench for tx_packet_sequencer: packet vector table plus reset, illegal-start and back-to-back sequences.
module tb_tx_packet_sequencer;

    typedef struct {
        logic [6:0]      len;
        int              n_bytes;
        logic [3:0][7:0] bytes;
        int              loads;
        int              eop_off;
        logic            underrun;
        int              extra_start_off;
    } pkt_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [6:0] tx_len;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_rd;
    logic       load_enable;
    logic [7:0] data;
    logic       eop;
    logic       busy;
    logic       tx_done;
    logic       underrun;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] fifo_q[$];
    pkt_vec_t   vecs[7];

    tx_packet_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_len      (tx_len),
        .fifo_rdata  (fifo_rdata),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .load_enable (load_enable),
        .data        (data),
        .eop         (eop),
        .busy        (busy),
        .tx_done     (tx_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] out_vec();
        return {load_enable, data, fifo_rd, eop, busy, tx_done, underrun};
    endfunction

    // Expected {load, data, rd, eop, busy, done, underrun} at a cycle offset from the accepted start.
    function automatic logic [13:0] expect_at(input pkt_vec_t v, input int off);
        int         k;
        logic       ld;
        logic       rd;
        logic [7:0] d;
        k  = (off - 1) / 8;
        ld = (off >= 1) && (((off - 1) % 8) == 0) && (k <= v.loads) && (off < v.eop_off);
        rd = ld && (k >= 1);
        d  = 8'h00;
        if (ld) begin
            if (k == 0) d = 8'h80;
            else        d = v.bytes[k-1];
        end
        return {ld, d, rd, off == v.eop_off, (off >= 1) && (off <= v.eop_off),
                off == v.eop_off + 1, (off == v.eop_off) && v.underrun};
    endfunction

    task automatic update_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic step();
        logic pop;
        pop = fifo_rd;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        update_fifo();
    endtask

    task automatic applyStimulus(input logic start, input logic [6:0] len);
        tx_start = start;
        tx_len   = len;
    endtask

    task automatic checkOutput(input string name, input int off, input logic [13:0] exp_v);
        logic [13:0] act;
        act    = out_vec();
        checks = checks + 1;
        if (act !== exp_v) begin
            failures = failures + 1;
            $display("[TB] FAIL %s off=%0d got={ld,data,rd,eop,busy,done,und}=%b_%h_%b expected=%b_%h_%b",
                     name, off, act[13], act[12:5], act[4:0], exp_v[13], exp_v[12:5], exp_v[4:0]);
        end
    endtask

    task automatic load_fifo(input pkt_vec_t v);
        fifo_q.delete();
        for (int j = 0; j < v.n_bytes; j++) fifo_q.push_back(v.bytes[j]);
        update_fifo();
    endtask

    // When pre_started is set the caller already drove tx_start in the current cycle.
    task automatic runPacket(input pkt_vec_t v, input bit pre_started, input bit chain_next, input string name);
        load_fifo(v);
        if (!pre_started) applyStimulus(1'b1, v.len);
        step();
        for (int off = 1; off <= v.eop_off + 1; off++) begin
            if (off == v.extra_start_off) applyStimulus(1'b1, 7'd1);
            else                          applyStimulus(1'b0, 7'd0);
            checkOutput(name, off, expect_at(v, off));
            if (!(chain_next && off == v.eop_off + 1)) step();
        end
        if (!chain_next) begin
            checkOutput({name, "_idle"}, v.eop_off + 2, 14'h0);
            fifo_q.delete();
            update_fifo();
        end
    endtask

    initial begin
        vecs[0] = '{7'd2,  2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 2, 25, 1'b0, -1};
        vecs[1] = '{7'd0,  0, {8'h00, 8'h00, 8'h00, 8'h00}, 0,  9, 1'b0, -1};
        vecs[2] = '{7'd3,  1, {8'h00, 8'h00, 8'h00, 8'h11}, 1, 17, 1'b1, -1};
        vecs[3] = '{7'd1,  2, {8'h00, 8'h00, 8'hC3, 8'h5A}, 1, 17, 1'b0, -1};
        vecs[4] = '{7'd64, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 0,  9, 1'b1, -1};
        vecs[5] = '{7'd2,  2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 2, 25, 1'b0,  5};
        vecs[6] = '{7'd4,  4, {8'h80, 8'h7E, 8'hFE, 8'h01}, 4, 41, 1'b0, -1};

        rst = 1'b1;
        applyStimulus(1'b0, 7'd0);
        fifo_q.delete();
        update_fifo();
        step();
        step();
        checkOutput("reset", 0, 14'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            runPacket(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
            step();
        end

        // Over-length request in IDLE must leave everything quiet.
        fifo_q.push_back(8'h99);
        update_fifo();
        applyStimulus(1'b1, 7'd65);
        step();
        applyStimulus(1'b0, 7'd0);
        for (int c = 1; c <= 12; c++) begin
            checkOutput("len65", c, 14'h0);
            step();
        end
        fifo_q.delete();
        update_fifo();

        // Reset sampled at T+12 aborts the packet without an eop.
        load_fifo(vecs[0]);
        applyStimulus(1'b1, 7'd2);
        step();
        applyStimulus(1'b0, 7'd0);
        checkOutput("rst_sync", 1, {1'b1, 8'h80, 5'b00100});
        for (int c = 2; c <= 12; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst_mid", 13, 14'h0);
        step();
        applyStimulus(1'b1, 7'd0);
        step();
        applyStimulus(1'b0, 7'd0);
        checkOutput("rst_restart", 15, {1'b1, 8'h80, 5'b00100});
        for (int c = 16; c <= 23; c++) step();
        checkOutput("rst_restart_eop", 23, {1'b0, 8'h00, 5'b01100});
        step();
        checkOutput("rst_restart_done", 24, {1'b0, 8'h00, 5'b00010});
        fifo_q.delete();
        update_fifo();
        step();

        // Second start issued in the tx_done cycle of the first packet.
        runPacket(vecs[0], 1'b0, 1'b1, "b2b_first");
        applyStimulus(1'b1, vecs[6].len);
        runPacket(vecs[6], 1'b1, 1'b0, "b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_packet_sequencer.md
Name: tx_packet_sequencer

Overview:
Controller that sequences the transmit parallel-to-serial shifter for one outgoing USB packet. It prepends a SYNC byte and pulls payload bytes from a show-ahead TX FIFO. It pulses load_enable exactly every 8 cycles so the shifter never starves. It then raises eop to stop shifting. It sits between the packet/encryption FIFO and the shifter, whose shift runs every cycle while its ready is high.

Parameters:
MAX_LEN, 64, maximum payload bytes per packet
LEN_W, 7, width of tx_len (must hold MAX_LEN)
SYNC_BYTE, 8'h80, first byte loaded every packet

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_start  in  1  one-cycle request to send a packet
tx_len  in  LEN_W  payload byte count, sampled with tx_start
fifo_rdata  in  8  head-of-FIFO byte (show-ahead)
fifo_empty  in  1  FIFO has no byte
fifo_rd  out  1  pop FIFO head this cycle
load_enable  out  1  load shifter with data this cycle
data  out  8  byte to shifter; 0 when load_enable=0
eop  out  1  one-cycle end-of-packet to shifter
busy  out  1  packet in progress
tx_done  out  1  one-cycle pulse, packet finished
underrun  out  1  one-cycle pulse, FIFO empty when byte was due

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. State goes to IDLE. All outputs are 0 the cycle after rst is sampled high. Counters clear. rst has priority over everything, including mid-packet: no eop is issued.
- All outputs are registered.
- States: IDLE, SHIFT, EOP.
- IDLE:
  - tx_start=1 with tx_len<=MAX_LEN: latch tx_len into rem_cnt, go to SHIFT.
  - tx_start=1 with tx_len>MAX_LEN: ignored.
  - busy=0.
- Timing from tx_start sampled at cycle T:
  - T+1: load_enable=1, data=SYNC_BYTE, busy=1, bit_cnt=0.
  - bit_cnt counts 0..7 every cycle in SHIFT and wraps at 7.
  - A load is due each time bit_cnt wraps, i.e. at T+1+8k.
- At load k≥1 (a data byte is due):
  - rem_cnt>0 and fifo_empty=0: load_enable=1, data=fifo_rdata, fifo_rd=1, rem_cnt decrements.
  - rem_cnt>0 and fifo_empty=1: no load and no fifo_rd. eop=1 and underrun=1 in the same cycle. Go to EOP.
  - rem_cnt==0 (all bytes loaded): eop=1, no load. Go to EOP.
- Normal eop timing:
  - Normal packet: eop at T+1+8*(tx_len+1).
  - tx_len=0: SYNC only, eop at T+9.
- EOP state (one cycle): tx_done=1, busy=0, return to IDLE. A tx_start sampled in this cycle is accepted, giving back-to-back packets.
- tx_start while busy=1 is ignored.
- fifo_rd is only ever asserted together with load_enable.
- fifo_rd is never asserted while fifo_empty=1.
- Widths:
  - rem_cnt is LEN_W bits and never underflows.
  - bit_cnt is 3 bits and wraps naturally.

Decomposition:
- Package tx_seq_pkg:
  - state enum (IDLE, SHIFT, EOP)
  - SYNC_BYTE and MAX_LEN defaults
  - BYTE_BITS=8 constant
- Sub-module tx_bit_counter: 3-bit wrapping counter with clear/enable and a wrap flag output. It is reusable by the receive side.

Test Plan:
1. Normal packet. tx_start at T with tx_len=2; FIFO holds A5, 3C.
   -> load 80 at T+1; load A5 with fifo_rd at T+9; load 3C with fifo_rd at T+17; eop at T+25; tx_done at T+26; busy=1 over T+1..T+25.
2. Zero-length packet. tx_len=0.
   -> load 80 at T+1; eop at T+9; tx_done at T+10; fifo_rd never asserted.
3. Underrun. tx_len=3; FIFO holds one byte (11).
   -> load 11 at T+9; at T+17 no load, eop=1 and underrun=1; tx_done at T+18; no further fifo_rd.
4. Illegal starts. tx_len=65 in IDLE -> no activity. tx_start at T+5 during a packet -> ignored; timing identical to scenario 1.
5. Reset mid-packet. rst at T+12 in scenario 1.
   -> at T+13 all outputs 0 and no eop; a new tx_start at T+14 gives load 80 at T+15.
6. Back-to-back. Second tx_start in the tx_done cycle (T+26 of scenario 1).
   -> load 80 at T+27 with correct subsequent timing.
